seg7_scanner: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits directly downstream of the single-cycle CPU's register-select mux and consumes the 16-bit register value chosen by the board switches. It shows that value as four hex digits. The value is snapshotted once per frame so the display never tears mid-scan, and a one-cycle frame strobe marks each completed frame.

---
 rtl/seg7_scanner.sv | 154 +++++++++++++++
 tb/tb_seg7_scanner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scanner.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : seg7_scanner
// Description : Time-multiplexed driver for a 4-digit common-anode seven-
//               segment display. Shows a 16-bit value as four hex digits,
//               snapshotting the value once per frame so a scan never tears,
//               and pulses frame_done after every completed frame.
// Parameters  : CLK_DIV      - clk cycles each digit stays lit (2..2^20)
// Ports       : clk          - system clock, rising edge
//               reset        - asynchronous, active-low
//               enable       - 1 = scan, 0 = blank display and hold counters
//               data[15:0]   - value to display, sampled at frame start
//               an[3:0]      - digit anodes, active-low, an[0] rightmost
//               digitalTube[7:0] - segments, active-low, {dp,g,f,e,d,c,b,a}
//               frame_done   - one-cycle pulse after each completed frame
// Options     : SEG7_LEADING_ZERO_BLANK_EN - when defined, digits above the
//               most significant nonzero nibble are blanked (digit 0 never).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module seg7_scanner #(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] data,
    output logic [3:0]  an,
    output logic [7:0]  digitalTube,
    output logic        frame_done
);

    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_digit;
    logic [15:0]        r_snap;
    logic [3:0]         r_an;
    logic [7:0]         r_seg;
    logic               r_frame_done;

    logic [3:0]         w_nibble;
    logic [7:0]         w_seg;

    // Active-low segment patterns, decimal point always off.
    function automatic logic [7:0] f_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    assign w_nibble = r_snap[{r_digit, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Index of the most significant nonzero nibble; 0 when the snapshot is
    // all zero so that digit 0 always shows something.
    logic [1:0] w_msd;

    always_comb begin
        w_msd = 2'd0;
        if (r_snap[7:4]   != 4'h0) w_msd = 2'd1;
        if (r_snap[11:8]  != 4'h0) w_msd = 2'd2;
        if (r_snap[15:12] != 4'h0) w_msd = 2'd3;
    end

    assign w_seg = (r_digit > w_msd) ? 8'hFF : f_decode(w_nibble);
`else
    assign w_seg = f_decode(w_nibble);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_div        <= '0;
            r_digit      <= 2'd0;
            r_snap       <= 16'h0000;
            r_an         <= 4'hF;
            r_seg        <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_an         <= 4'hF;
                    r_seg        <= 8'hFF;
                    r_frame_done <= 1'b0;
                    if (enable) begin
                        r_snap  <= data;
                        r_digit <= 2'd0;
                        r_div   <= '0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (enable) begin
                        // Outputs follow the current digit/snapshot, so they
                        // lag any counter change by one cycle.
                        r_an         <= ~(4'b0001 << r_digit);
                        r_seg        <= w_seg;
                        r_frame_done <= 1'b0;
                        if (r_div == c_DIV_LAST) begin
                            r_div   <= '0;
                            r_digit <= r_digit + 2'd1;
                            // Last digit of the frame: take the next snapshot
                            // on the same edge the digit wraps to 0.
                            if (r_digit == 2'd3) begin
                                r_snap       <= data;
                                r_frame_done <= 1'b1;
                            end
                        end else begin
                            r_div <= r_div + c_DIV_W'(1);
                        end
                    end else begin
                        // Paused: blank, but keep div/digit/snap for resume.
                        r_an         <= 4'hF;
                        r_seg        <= 8'hFF;
                        r_frame_done <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign an          = r_an;
    assign digitalTube = r_seg;
    // A pulse landing in a cycle where enable has already dropped is
    // suppressed: frame_done never shows while the display is paused.
    assign frame_done  = r_frame_done & enable;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scanner.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_seg7_scanner
// Description : Self-checking bench for seg7_scanner (CLK_DIV = 4). A
//               time-based reference model derives the lit digit from the
//               number of enabled scan cycles since start-up and the frame
//               snapshot from frame boundaries.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_seg7_scanner;

    localparam int c_CLK_DIV = 4;
    localparam int c_FRAME   = 4 * c_CLK_DIV;
    localparam logic [7:0] c_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  an;
    logic [7:0]  digitalTube;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scanner #(.CLK_DIV(c_CLK_DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .data        (data),
        .an          (an),
        .digitalTube (digitalTube),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Expected segment code for digit d of a displayed value.
    function automatic logic [7:0] f_code(input logic [15:0] v, input int d);
        logic [3:0] nib;
        nib = v[d*4 +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin
            int msd;
            msd = 0;
            for (int i = 1; i < 4; i++) if (v[i*4 +: 4] != 4'h0) msd = i;
            if (d > msd) return 8'hFF;
        end
`endif
        return c_SEG[nib];
    endfunction

    //--------------------------------------------------------------------
    // Reference model: m_t counts enabled scan cycles since start-up; the
    // lit digit is (m_t / CLK_DIV) mod 4 and every 4*CLK_DIV cycles a
    // frame completes and the snapshot reloads.
    //--------------------------------------------------------------------
    bit          m_active = 0;
    int          m_t      = 0;
    logic [15:0] m_snap   = 16'h0000;
    logic [3:0]  e_an     = 4'hF;
    logic [7:0]  e_dt     = 8'hFF;
    logic        e_fd     = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 0; m_t = 0; m_snap = 16'h0000;
            e_an = 4'hF; e_dt = 8'hFF; e_fd = 1'b0;
        end else if (!m_active) begin
            if (enable) begin
                m_active = 1; m_t = 0; m_snap = data;
            end
            e_an = 4'hF; e_dt = 8'hFF; e_fd = 1'b0;
        end else if (enable) begin
            int d;
            d = (m_t / c_CLK_DIV) % 4;
            e_an = 4'hF ^ (4'h1 << d);
            e_dt = f_code(m_snap, d);
            m_t++;
            e_fd = ((m_t % c_FRAME) == 0);
            if (e_fd) m_snap = data;
        end else begin
            e_an = 4'hF; e_dt = 8'hFF; e_fd = 1'b0;
        end
    end

    //--------------------------------------------------------------------
    task automatic test_reset();
        int pulses;
        reset = 1'b0; enable = 1'b1; data = 16'h1234;
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %h expected F", an); end
            n_checks++; if (digitalTube !== 8'hFF) begin n_fail++; $display("FAIL reset_dt: got %h expected FF", digitalTube); end
            n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
        end
        reset = 1'b1;
        @(negedge clk);  // edge 1: enters scanning, still blank
        n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL start_edge1_an: got %h expected F", an); end
        @(negedge clk);  // edge 2: first lit digit
        n_checks++; if (an !== 4'hE) begin n_fail++; $display("FAIL start_edge2_an: got %h expected E", an); end
        n_checks++; if (digitalTube !== 8'h99) begin n_fail++; $display("FAIL start_edge2_dt: got %h expected 99", digitalTube); end
        pulses = 0;
        for (int i = 0; i < 2 * c_FRAME; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) pulses++;
            n_checks++; if (an !== e_an) begin n_fail++; $display("FAIL startup_an: cyc %0d got %h expected %h", i, an, e_an); end
            n_checks++; if (digitalTube !== e_dt) begin n_fail++; $display("FAIL startup_dt: cyc %0d got %h expected %h", i, digitalTube, e_dt); end
            n_checks++; if (frame_done !== (e_fd & enable)) begin n_fail++; $display("FAIL startup_fd: cyc %0d got %b expected %b", i, frame_done, e_fd & enable); end
        end
        n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL startup_fd_count: got %0d expected 2", pulses); end
    endtask

    //--------------------------------------------------------------------
    task automatic test_snapshot();
        int  guard;
        bit  seen_fd;
        guard = 0;
        while (e_an !== 4'hD && guard < 64) begin @(negedge clk); guard++; end
        n_checks++; if (guard >= 64) begin n_fail++; $display("FAIL snap_wait_digit1: got timeout expected digit 1 lit"); end
        data = 16'hABCD;
        seen_fd = 0;
        for (int i = 0; i < 2 * c_FRAME; i++) begin
            @(negedge clk);
            n_checks++; if (an !== e_an) begin n_fail++; $display("FAIL snap_an: cyc %0d got %h expected %h", i, an, e_an); end
            n_checks++; if (digitalTube !== e_dt) begin n_fail++; $display("FAIL snap_dt: cyc %0d got %h expected %h", i, digitalTube, e_dt); end
            n_checks++; if (frame_done !== (e_fd & enable)) begin n_fail++; $display("FAIL snap_fd: cyc %0d got %b expected %b", i, frame_done, e_fd & enable); end
            if (!seen_fd && an === 4'h7) begin
                n_checks++; if (digitalTube !== 8'hF9) begin n_fail++; $display("FAIL snap_old_digit3: got %h expected F9", digitalTube); end
            end
            if (seen_fd && an === 4'hE) begin
                n_checks++; if (digitalTube !== 8'hA1) begin n_fail++; $display("FAIL snap_new_digit0: got %h expected A1", digitalTube); end
            end
            if (seen_fd && an === 4'h7) begin
                n_checks++; if (digitalTube !== 8'h88) begin n_fail++; $display("FAIL snap_new_digit3: got %h expected 88", digitalTube); end
            end
            if (frame_done === 1'b1) seen_fd = 1;
        end
        n_checks++; if (!seen_fd) begin n_fail++; $display("FAIL snap_boundary: got no frame_done expected one"); end
    endtask

    //--------------------------------------------------------------------
    task automatic test_enable_hold();
        int guard;
        int lit;
        guard = 0;
        while (e_an === 4'hB && guard < 64) begin @(negedge clk); guard++; end
        while (e_an !== 4'hB && guard < 64) begin @(negedge clk); guard++; end
        n_checks++; if (guard >= 64) begin n_fail++; $display("FAIL hold_wait_digit2: got timeout expected digit 2 lit"); end
        lit = 1;
        @(negedge clk);
        n_checks++; if (an !== 4'hB) begin n_fail++; $display("FAIL hold_pre_an: got %h expected B", an); end
        if (an === 4'hB) lit++;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL hold_an: cyc %0d got %h expected F", i, an); end
            n_checks++; if (digitalTube !== 8'hFF) begin n_fail++; $display("FAIL hold_dt: cyc %0d got %h expected FF", i, digitalTube); end
            n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL hold_fd: cyc %0d got %b expected 0", i, frame_done); end
        end
        enable = 1'b1;
        guard = 0;
        while (an !== 4'h7 && guard < 20) begin
            @(negedge clk);
            guard++;
            if (an === 4'hB) lit++;
            n_checks++; if (an !== e_an) begin n_fail++; $display("FAIL resume_an: cyc %0d got %h expected %h", guard, an, e_an); end
            n_checks++; if (digitalTube !== e_dt) begin n_fail++; $display("FAIL resume_dt: cyc %0d got %h expected %h", guard, digitalTube, e_dt); end
        end
        n_checks++; if (lit != c_CLK_DIV) begin n_fail++; $display("FAIL hold_lit_cycles: got %0d expected %0d", lit, c_CLK_DIV); end
    endtask

    //--------------------------------------------------------------------
    task automatic test_async_reset();
        logic [15:0] v;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL async_an: got %h expected F", an); end
        n_checks++; if (digitalTube !== 8'hFF) begin n_fail++; $display("FAIL async_dt: got %h expected FF", digitalTube); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL async_fd: got %b expected 0", frame_done); end
        @(negedge clk);
        v = 16'($urandom);
        data = v;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL restart_edge1_an: got %h expected F", an); end
        @(negedge clk);
        n_checks++; if (an !== 4'hE) begin n_fail++; $display("FAIL restart_an: got %h expected E", an); end
        n_checks++; if (digitalTube !== f_code(v, 0)) begin n_fail++; $display("FAIL restart_dt: got %h expected %h", digitalTube, f_code(v, 0)); end
    endtask

    //--------------------------------------------------------------------
    task automatic test_decode_sweep();
        logic [15:0] vals [$];
        vals = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        vals.push_back(16'h0000);
`endif
        foreach (vals[k]) begin
            int guard;
            data = vals[k];
            guard = 0;
            do begin @(negedge clk); guard++; end while (!(frame_done === 1'b1) && guard < 40);
            n_checks++; if (guard >= 40) begin n_fail++; $display("FAIL sweep_wait_frame: value %h got timeout", vals[k]); end
            for (int i = 0; i < c_FRAME; i++) begin
                int d;
                @(negedge clk);
                d = i / c_CLK_DIV;
                n_checks++; if (an !== (4'hF ^ (4'h1 << d))) begin n_fail++; $display("FAIL sweep_an: value %h digit %0d got %h", vals[k], d, an); end
                n_checks++; if (digitalTube !== f_code(vals[k], d)) begin n_fail++; $display("FAIL sweep_dt: value %h digit %0d got %h expected %h", vals[k], d, digitalTube, f_code(vals[k], d)); end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (vals[k] == 16'h0000) begin
                    n_checks++; if (digitalTube !== ((d == 0) ? 8'hC0 : 8'hFF)) begin n_fail++; $display("FAIL sweep_zero_blank: digit %0d got %h", d, digitalTube); end
                end
`endif
            end
        end
    endtask

    //--------------------------------------------------------------------
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_checks++; if (an !== e_an) begin n_fail++; $display("FAIL rand_an: cyc %0d got %h expected %h", i, an, e_an); end
            n_checks++; if (digitalTube !== e_dt) begin n_fail++; $display("FAIL rand_dt: cyc %0d got %h expected %h", i, digitalTube, e_dt); end
            n_checks++; if (frame_done !== (e_fd & enable)) begin n_fail++; $display("FAIL rand_fd: cyc %0d got %b expected %b", i, frame_done, e_fd & enable); end
            if ($urandom_range(7) == 0) data = 16'($urandom);
            if ($urandom_range(15) == 0) enable = ~enable;
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_enable_hold();
        test_async_reset();
        test_decode_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
